// File: rtl/ttt_board_referee.sv
// ttt_board_referee: board store and move referee for a two-player
// tic-tac-toe game. It checks the game FSM's one-hot move each play
// cycle (combinational illegal flag), commits legal moves into the
// per-player occupancy boards, and registers the win/tie result
// evaluated on the committed boards.
//
// Optional build macro: TTT_REFEREE_SCORE_EN adds the p1_score/p2_score
// counters (cleared only by reset_n, saturating at 15).
module ttt_board_referee #(
  parameter logic [2:0] P1_PLAY = 3'b001,
  parameter logic [2:0] P2_PLAY = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic [2:0] S,
  input  logic [8:0] position_reg,
  output logic       illegal,
  output logic [1:0] win,
  output logic [8:0] board_p1,
  output logic [8:0] board_p2,
  output logic [3:0] move_count,
  output logic       game_over
`ifdef TTT_REFEREE_SCORE_EN
  ,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score
`endif
);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  logic [8:0] board_p1_q, board_p1_d;
  logic [8:0] board_p2_q, board_p2_d;
  logic [3:0] move_count_q, move_count_d;
  logic [1:0] win_q, win_d;
  logic       game_over_q, game_over_d;
  logic [1:0] win_next;
  logic       play_cycle;
  logic       commit;

  // True when exactly one bit of the move vector is set.
  function automatic logic is_one_hot(input logic [8:0] v);
    is_one_hot = (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  // True when the board holds any of the eight three-in-a-row lines.
  function automatic logic has_line(input logic [8:0] b);
    has_line = (&b[2:0]) | (&b[5:3]) | (&b[8:6])
             | (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8])
             | (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Move legality is decided in the same cycle so the FSM can react at once.
  always_comb begin
    play_cycle = (S == P1_PLAY) || (S == P2_PLAY);
    illegal    = 1'b0;
    if (play_cycle) begin
      illegal = !is_one_hot(position_reg)
              || ((position_reg & (board_p1_q | board_p2_q)) != 9'd0)
              || game_over_q;
    end
    commit = play_cycle && !illegal;
  end

  // Result of the currently committed boards; P1 wins ahead of P2 if both
  // lines ever appear together.
  always_comb begin
    win_next = WIN_NONE;
    if (has_line(board_p1_q)) begin
      win_next = WIN_P1;
    end else if (has_line(board_p2_q)) begin
      win_next = WIN_P2;
    end else if (move_count_q == 4'd9) begin
      win_next = WIN_TIE;
    end
  end

  // Next-state: new_game wipes everything and beats a same-edge commit.
  always_comb begin
    board_p1_d   = board_p1_q;
    board_p2_d   = board_p2_q;
    move_count_d = move_count_q;
    win_d        = win_next;
    game_over_d  = (win_next != WIN_NONE);
    if (new_game) begin
      board_p1_d   = 9'd0;
      board_p2_d   = 9'd0;
      move_count_d = 4'd0;
      win_d        = WIN_NONE;
      game_over_d  = 1'b0;
    end else if (commit) begin
      if (S == P1_PLAY) begin
        board_p1_d = board_p1_q | position_reg;
      end else begin
        board_p2_d = board_p2_q | position_reg;
      end
      if (move_count_q != 4'd9) begin
        move_count_d = move_count_q + 4'd1;
      end
    end
  end

  // Board, move count and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board_p1_q   <= 9'd0;
      board_p2_q   <= 9'd0;
      move_count_q <= 4'd0;
      win_q        <= WIN_NONE;
      game_over_q  <= 1'b0;
    end else begin
      board_p1_q   <= board_p1_d;
      board_p2_q   <= board_p2_d;
      move_count_q <= move_count_d;
      win_q        <= win_d;
      game_over_q  <= game_over_d;
    end
  end

  assign board_p1   = board_p1_q;
  assign board_p2   = board_p2_q;
  assign move_count = move_count_q;
  assign win        = win_q;
  assign game_over  = game_over_q;

`ifdef TTT_REFEREE_SCORE_EN
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;

  // A score bumps once, on the edge where the result first turns into a win.
  always_comb begin
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    if (win_q == WIN_NONE) begin
      if ((win_d == WIN_P1) && (p1_score_q != 4'd15)) begin
        p1_score_d = p1_score_q + 4'd1;
      end
      if ((win_d == WIN_P2) && (p2_score_q != 4'd15)) begin
        p2_score_d = p2_score_q + 4'd1;
      end
    end
  end

  // Scores survive new_game; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
    end else begin
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
    end
  end

  assign p1_score = p1_score_q;
  assign p2_score = p2_score_q;
`endif

endmodule

// File: tb/tb_ttt_board_referee.sv
// Directed, table-driven bench for ttt_board_referee. Each table row is
// one clock: the inputs, the expected same-cycle illegal flag, and the
// expected registered outputs just after the edge that ends the cycle.
module tb_ttt_board_referee;

  logic       clk;
  logic       reset_n;
  logic       new_game;
  logic [2:0] S;
  logic [8:0] position_reg;
  logic       illegal;
  logic [1:0] win;
  logic [8:0] board_p1;
  logic [8:0] board_p2;
  logic [3:0] move_count;
  logic       game_over;
`ifdef TTT_REFEREE_SCORE_EN
  logic [3:0] p1_score;
  logic [3:0] p2_score;
`endif

  ttt_board_referee dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .S            (S),
    .position_reg (position_reg),
    .illegal      (illegal),
    .win          (win),
    .board_p1     (board_p1),
    .board_p2     (board_p2),
    .move_count   (move_count),
    .game_over    (game_over)
`ifdef TTT_REFEREE_SCORE_EN
    ,
    .p1_score     (p1_score),
    .p2_score     (p2_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ng;
    logic [2:0] s;
    logic [8:0] pos;
    logic       ill;
    logic [8:0] p1;
    logic [8:0] p2;
    logic [3:0] cnt;
    logic [1:0] win;
    logic       go;
  } vec_t;

  vec_t tbl[$];
  int   n_checks;
  int   n_fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ng, input logic [2:0] s, input logic [8:0] pos,
                     input logic ill, input logic [8:0] p1, input logic [8:0] p2,
                     input logic [3:0] cnt, input logic [1:0] w, input logic go);
    vec_t v;
    v.ng = ng; v.s = s; v.pos = pos; v.ill = ill; v.p1 = p1; v.p2 = p2;
    v.cnt = cnt; v.win = w; v.go = go;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge and wait past the rising edge.
  task automatic step(input logic ng, input logic [2:0] s, input logic [8:0] pos);
    @(negedge clk);
    new_game = ng; S = s; position_reg = pos;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n = 1'b0; new_game = 1'b0; S = 3'b000; position_reg = 9'd0;

    // Game A: rejections, then P1 takes the top row.
    add(0, 3'b001, 9'h001, 0, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b100, 9'h001, 1, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b001, 9'h003, 1, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b001, 9'h000, 1, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b010, 9'h002, 0, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b100, 9'h008, 0, 9'h001, 9'h008, 4'd2, 2'b00, 0);
    add(0, 3'b001, 9'h002, 0, 9'h003, 9'h008, 4'd3, 2'b00, 0);
    add(0, 3'b100, 9'h010, 0, 9'h003, 9'h018, 4'd4, 2'b00, 0);
    add(0, 3'b001, 9'h004, 0, 9'h007, 9'h018, 4'd5, 2'b00, 0);
    add(0, 3'b000, 9'h000, 0, 9'h007, 9'h018, 4'd5, 2'b01, 1);
    add(0, 3'b100, 9'h020, 1, 9'h007, 9'h018, 4'd5, 2'b01, 1);
    add(1, 3'b000, 9'h000, 0, 9'h000, 9'h000, 4'd0, 2'b00, 0);
    // new_game wins over a legal same-edge move.
    add(1, 3'b001, 9'h001, 0, 9'h000, 9'h000, 4'd0, 2'b00, 0);
    // Game B: full board, no line -> tie.
    add(0, 3'b001, 9'h001, 0, 9'h001, 9'h000, 4'd1, 2'b00, 0);
    add(0, 3'b100, 9'h004, 0, 9'h001, 9'h004, 4'd2, 2'b00, 0);
    add(0, 3'b001, 9'h002, 0, 9'h003, 9'h004, 4'd3, 2'b00, 0);
    add(0, 3'b100, 9'h008, 0, 9'h003, 9'h00C, 4'd4, 2'b00, 0);
    add(0, 3'b001, 9'h020, 0, 9'h023, 9'h00C, 4'd5, 2'b00, 0);
    add(0, 3'b100, 9'h010, 0, 9'h023, 9'h01C, 4'd6, 2'b00, 0);
    add(0, 3'b001, 9'h040, 0, 9'h063, 9'h01C, 4'd7, 2'b00, 0);
    add(0, 3'b100, 9'h080, 0, 9'h063, 9'h09C, 4'd8, 2'b00, 0);
    add(0, 3'b001, 9'h100, 0, 9'h163, 9'h09C, 4'd9, 2'b00, 0);
    add(0, 3'b000, 9'h000, 0, 9'h163, 9'h09C, 4'd9, 2'b11, 1);
    add(0, 3'b001, 9'h001, 1, 9'h163, 9'h09C, 4'd9, 2'b11, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset board_p1", board_p1, 9'h000);
    chk("reset board_p2", board_p2, 9'h000);
    chk("reset move_count", move_count, 4'd0);
    chk("reset win", win, 2'b00);
    chk("reset game_over", game_over, 1'b0);
    chk("reset illegal", illegal, 1'b0);
`ifdef TTT_REFEREE_SCORE_EN
    chk("reset p1_score", p1_score, 4'd0);
    chk("reset p2_score", p2_score, 4'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      new_game = tbl[i].ng; S = tbl[i].s; position_reg = tbl[i].pos;
      #1;
      chk($sformatf("row%0d illegal", i), illegal, tbl[i].ill);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d board_p1", i), board_p1, tbl[i].p1);
      chk($sformatf("row%0d board_p2", i), board_p2, tbl[i].p2);
      chk($sformatf("row%0d move_count", i), move_count, tbl[i].cnt);
      chk($sformatf("row%0d win", i), win, tbl[i].win);
      chk($sformatf("row%0d game_over", i), game_over, tbl[i].go);
    end

    // P2 wins on the middle row; the result appears one edge after the commit.
    step(1, 3'b000, 9'h000);
    step(0, 3'b001, 9'h001);
    step(0, 3'b100, 9'h008);
    step(0, 3'b001, 9'h002);
    step(0, 3'b100, 9'h010);
    step(0, 3'b001, 9'h100);
    step(0, 3'b100, 9'h020);
    chk("p2win board_p2", board_p2, 9'h038);
    chk("p2win win at commit", win, 2'b00);
    step(0, 3'b000, 9'h000);
    chk("p2win win", win, 2'b10);
    chk("p2win game_over", game_over, 1'b1);
    step(0, 3'b000, 9'h000);
    chk("p2win win held", win, 2'b10);
`ifdef TTT_REFEREE_SCORE_EN
    chk("p2win p2_score once", p2_score, 4'd1);
    chk("p2win p1_score", p1_score, 4'd1);
`endif
    step(1, 3'b000, 9'h000);
    chk("new_game board_p2", board_p2, 9'h000);
    chk("new_game win", win, 2'b00);
    chk("new_game game_over", game_over, 1'b0);
`ifdef TTT_REFEREE_SCORE_EN
    chk("new_game p2_score kept", p2_score, 4'd1);
    chk("new_game p1_score kept", p1_score, 4'd1);
`endif

    // Mid-game asynchronous reset, asserted well away from any rising edge.
    step(0, 3'b001, 9'h001);
    step(0, 3'b100, 9'h010);
    chk("midgame board_p1", board_p1, 9'h001);
    chk("midgame move_count", move_count, 4'd2);
    @(negedge clk);
    S = 3'b000; position_reg = 9'd0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset board_p1", board_p1, 9'h000);
    chk("async reset board_p2", board_p2, 9'h000);
    chk("async reset move_count", move_count, 4'd0);
    chk("async reset win", win, 2'b00);
`ifdef TTT_REFEREE_SCORE_EN
    chk("async reset p1_score", p1_score, 4'd0);
    chk("async reset p2_score", p2_score, 4'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 3'b100, 9'h100);
    chk("post reset board_p2", board_p2, 9'h100);
    chk("post reset move_count", move_count, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
